ctrl_pkg_xcvr_param: RTL

Parametrised control-package transceiver for the STN FPGA control link. It serialises one `PKG_W`-bit package plus a `PAD_W`-bit constant trailer over a `LANE_W`-bit lane, and deserialises incoming frames framed by `ctrl_rx_dv`. New relative to the fixed 128-bit/2-lane generation:
- frame-length and padding checking with an explicit error flag;
- payload comparison against the last transmitted package, for loopback self-test;
- a busy flag and defined busy-start behaviour.

---
 rtl/ctrl_pkg_xcvr_param.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/ctrl_pkg_xcvr_param.sv
// ---------------------------------------------------------------------------
// ctrl_pkg_xcvr_param
//   Control-package transceiver for the FPGA control link. TX serialises one
//   PKG_W-bit package followed by a constant PAD_W-bit trailer, MSB first,
//   LANE_W bits per beat. RX deserialises frames framed by ctrl_rx_dv, checks
//   the length and trailer, and compares a good payload against the last
//   transmitted package so that a loopback can self-test the link.
//
// Ports
//   sys_clk, rst        clock (rising edge), synchronous active-high reset
//   tx_start            one-cycle start request (ignored while busy)
//   tx_package_i        payload, captured when a start is accepted
//   tx_busy, tx_done    frame shifting out / sticky completion flag
//   ctrl_tx_clk         forwarded clock (~sys_clk)
//   ctrl_tx_data/_en    TX lane and beat-valid
//   ctrl_rx_data/_dv    RX lane and beat-valid (one contiguous run per frame)
//   rx_package_o        last good received payload
//   rx_good, rx_err     verdict on the last frame (mutually exclusive)
//   rx_match            last good payload equals the last transmitted one
//   rx_bit_cnt_o        bits received in the current/last frame, saturating
// ---------------------------------------------------------------------------
module ctrl_pkg_xcvr_param #(
   parameter int unsigned      PKG_W   = 128,
   parameter int unsigned      LANE_W  = 2,
   parameter int unsigned      PAD_W   = 16,
   parameter logic [PAD_W-1:0] PAD_VAL = {PAD_W{1'b1}},
   parameter int unsigned      CNT_W   = 16
) (
   input  logic              sys_clk,
   input  logic              rst,
   input  logic              tx_start,
   input  logic [PKG_W-1:0]  tx_package_i,
   output logic              tx_busy,
   output logic              tx_done,
   output logic              ctrl_tx_clk,
   output logic [LANE_W-1:0] ctrl_tx_data,
   output logic              ctrl_tx_en,
   input  logic [LANE_W-1:0] ctrl_rx_data,
   input  logic              ctrl_rx_dv,
   output logic [PKG_W-1:0]  rx_package_o,
   output logic              rx_good,
   output logic              rx_err,
   output logic              rx_match,
   output logic [CNT_W-1:0]  rx_bit_cnt_o
);

   localparam int unsigned FRAME_W = PKG_W + PAD_W;
   localparam int unsigned BEATS   = FRAME_W / LANE_W;
   localparam int unsigned BCNT_W  = $clog2(BEATS + 1);

   localparam logic [BCNT_W-1:0] BEATS_LD  = BCNT_W'(BEATS);
   localparam logic [BCNT_W-1:0] BEAT_ONE  = BCNT_W'(1);
   localparam logic [CNT_W:0]    LANE_INC  = (CNT_W + 1)'(LANE_W);
   localparam logic [CNT_W-1:0]  LANE_CNT  = CNT_W'(LANE_W);
   localparam logic [CNT_W-1:0]  FRAME_CNT = CNT_W'(FRAME_W);

   typedef enum logic {TX_IDLE = 1'b0, TX_SHIFT = 1'b1} tx_state_e;
   typedef enum logic {RX_IDLE = 1'b0, RX_RECV  = 1'b1} rx_state_e;

   // Bit counter increment that sticks at all ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a);
      logic [CNT_W:0] sum;
      sum = {1'b0, a} + LANE_INC;
      if (sum[CNT_W]) begin
         sat_add = {CNT_W{1'b1}};
      end else begin
         sat_add = sum[CNT_W-1:0];
      end
   endfunction

   // ---------------- TX state ----------------
   tx_state_e           tx_state_q, tx_state_d;
   logic [FRAME_W-1:0]  tx_sr_q,    tx_sr_d;
   logic [BCNT_W-1:0]   tx_beat_q,  tx_beat_d;
   logic [PKG_W-1:0]    tx_ref_q,   tx_ref_d;
   logic                tx_busy_q,  tx_busy_d;
   logic                tx_done_q,  tx_done_d;

   // ---------------- RX state ----------------
   rx_state_e           rx_state_q, rx_state_d;
   logic [FRAME_W-1:0]  rx_sr_q,    rx_sr_d;
   logic [CNT_W-1:0]    rx_cnt_q,   rx_cnt_d;
   logic                rx_eof_q,   rx_eof_d;
   logic [PKG_W-1:0]    rx_pkg_q,   rx_pkg_d;
   logic                rx_good_q,  rx_good_d;
   logic                rx_err_q,   rx_err_d;
   logic                rx_match_q, rx_match_d;

   // TX next-state: load on an accepted start, then shift one beat per cycle.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_sr_d    = tx_sr_q;
      tx_beat_d  = tx_beat_q;
      tx_ref_d   = tx_ref_q;
      tx_busy_d  = tx_busy_q;
      tx_done_d  = tx_done_q;
      case (tx_state_q)
         TX_IDLE: begin
            if (tx_start) begin
               tx_sr_d    = {tx_package_i, PAD_VAL};
               tx_ref_d   = tx_package_i;
               tx_beat_d  = BEATS_LD;
               tx_busy_d  = 1'b1;
               tx_done_d  = 1'b0;
               tx_state_d = TX_SHIFT;
            end else begin
               tx_busy_d  = 1'b0;
            end
         end
         TX_SHIFT: begin
            // Zeros shift in, so the lane reads 0 once the frame has left.
            tx_sr_d   = tx_sr_q << LANE_W;
            tx_beat_d = tx_beat_q - BEAT_ONE;
            if (tx_beat_q == BEAT_ONE) begin
               tx_busy_d  = 1'b0;
               tx_done_d  = 1'b1;
               tx_state_d = TX_IDLE;
            end else begin
               tx_busy_d  = 1'b1;
            end
         end
         default: begin
            tx_busy_d  = 1'b0;
            tx_state_d = TX_IDLE;
         end
      endcase
   end

   // RX next-state: collect beats while dv is high, judge the frame one cycle
   // after dv is first seen low.
   always_comb begin
      rx_state_d = rx_state_q;
      rx_sr_d    = rx_sr_q;
      rx_cnt_d   = rx_cnt_q;
      rx_eof_d   = 1'b0;
      rx_pkg_d   = rx_pkg_q;
      rx_good_d  = rx_good_q;
      rx_err_d   = rx_err_q;
      rx_match_d = rx_match_q;
      case (rx_state_q)
         RX_IDLE: begin
            if (ctrl_rx_dv) begin
               rx_good_d  = 1'b0;
               rx_err_d   = 1'b0;
               rx_sr_d    = {rx_sr_q[FRAME_W-LANE_W-1:0], ctrl_rx_data};
               rx_cnt_d   = LANE_CNT;
               rx_state_d = RX_RECV;
            end else begin
               rx_state_d = RX_IDLE;
            end
         end
         RX_RECV: begin
            if (ctrl_rx_dv) begin
               rx_sr_d  = {rx_sr_q[FRAME_W-LANE_W-1:0], ctrl_rx_data};
               rx_cnt_d = sat_add(rx_cnt_q);
            end else begin
               rx_eof_d   = 1'b1;
               rx_state_d = RX_IDLE;
            end
         end
         default: begin
            rx_state_d = RX_IDLE;
         end
      endcase
      // Verdict uses the pre-edge shift register and count, which are still
      // the finished frame even if a new frame starts on this same edge; the
      // verdict then takes precedence over that frame's flag clear.
      if (rx_eof_q) begin
         if ((rx_cnt_q == FRAME_CNT) && (rx_sr_q[PAD_W-1:0] == PAD_VAL)) begin
            rx_good_d  = 1'b1;
            rx_err_d   = 1'b0;
            rx_pkg_d   = rx_sr_q[FRAME_W-1 -: PKG_W];
            rx_match_d = (rx_sr_q[FRAME_W-1 -: PKG_W] == tx_ref_q);
         end else begin
            rx_good_d  = 1'b0;
            rx_err_d   = 1'b1;
         end
      end else begin
         rx_match_d = rx_match_q;
      end
   end

   // State registers for both directions with synchronous reset.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         tx_state_q <= TX_IDLE;
         tx_sr_q    <= '0;
         tx_beat_q  <= '0;
         tx_ref_q   <= '0;
         tx_busy_q  <= 1'b0;
         tx_done_q  <= 1'b0;
         rx_state_q <= RX_IDLE;
         rx_sr_q    <= '0;
         rx_cnt_q   <= '0;
         rx_eof_q   <= 1'b0;
         rx_pkg_q   <= '0;
         rx_good_q  <= 1'b0;
         rx_err_q   <= 1'b0;
         rx_match_q <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_sr_q    <= tx_sr_d;
         tx_beat_q  <= tx_beat_d;
         tx_ref_q   <= tx_ref_d;
         tx_busy_q  <= tx_busy_d;
         tx_done_q  <= tx_done_d;
         rx_state_q <= rx_state_d;
         rx_sr_q    <= rx_sr_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_eof_q   <= rx_eof_d;
         rx_pkg_q   <= rx_pkg_d;
         rx_good_q  <= rx_good_d;
         rx_err_q   <= rx_err_d;
         rx_match_q <= rx_match_d;
      end
   end

   assign ctrl_tx_clk  = ~sys_clk;
   assign ctrl_tx_data = tx_sr_q[FRAME_W-1 -: LANE_W];
   assign ctrl_tx_en   = tx_busy_q;
   assign tx_busy      = tx_busy_q;
   assign tx_done      = tx_done_q;
   assign rx_package_o = rx_pkg_q;
   assign rx_good      = rx_good_q;
   assign rx_err       = rx_err_q;
   assign rx_match     = rx_match_q;
   assign rx_bit_cnt_o = rx_cnt_q;

endmodule
